// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile_sb register file.
//   state_e    : init-walk / normal-operation FSM states
//   *_DEF      : default parameter values for the MIPS core configuration
//   port_slice : extracts field k of width w from a flattened multi-port vector
package regfile_pkg;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NUM_RD_DEF = 2;

  // Widest flattened vector supported: 4 ports x 32 bits.
  localparam int unsigned SLICE_VEC_W = 128;

  // Callers zero-extend the flattened vector to SLICE_VEC_W and truncate the
  // result to their field width.
  function automatic logic [31:0] port_slice(input logic [SLICE_VEC_W-1:0] vec,
                                             input int unsigned k,
                                             input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return 32'(vec >> (k * w)) & mask;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
//   clk_i, rst_i            : clock, synchronous active-high reset (drops all claims)
//   run_i                   : high when the register file is in normal operation
//   claim_en_i/claim_addr_i : decode marks a destination register as pending
//   clr_en_i/clr_addr_i     : writeback retires the pending write
//   rd_addr_i               : flattened read addresses, port k at [k*ADDR_W +: ADDR_W]
//   bypass_hit_i            : per-port flag, the addressed register is written this cycle
//   rd_busy_o               : per-port busy flag
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     run_i,
  input  logic                     claim_en_i,
  input  logic [ADDR_W-1:0]        claim_addr_i,
  input  logic                     clr_en_i,
  input  logic [ADDR_W-1:0]        clr_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_RD-1:0]        bypass_hit_i,
  output logic [NUM_RD-1:0]        rd_busy_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             claim_ok;

  assign claim_ok = claim_en_i && !((ZERO_REG != 0) && (claim_addr_i == '0));

  // Claim is applied after clear so a new producer issuing while the old one
  // writes back keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (run_i) begin
      if (clr_en_i) begin
        busy_d[clr_addr_i] = 1'b0;
      end
      if (claim_ok) begin
        busy_d[claim_addr_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A register written this cycle reads as ready; the bypass supplies its value.
  always_comb begin
    rd_busy_o = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_busy_o[k] = run_i & busy_q[rd_addr_i[k*ADDR_W +: ADDR_W]] & ~bypass_hit_i[k];
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NUM_RD combinational read ports, one write port,
// write-to-read bypass and a pending-write scoreboard. After reset the array
// is cleared by a sequential walk so the storage needs no reset and can map
// to RAM.
//   clk, rst              : clock, synchronous active-high reset
//   init_busy             : high during reset and the clearing walk
//   rd_addr/rd_data       : flattened read ports, port k at slice k
//   rd_busy               : per-port outstanding-claim flag
//   wr_en/wr_addr/wr_data : writeback write port
//   claim_en/claim_addr   : decode destination claim
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_busy,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CntLast = (ADDR_W + 1)'(DEPTH - 1);

  state_e              state_q;
  logic [ADDR_W:0]     cnt_q;
  logic                init_busy_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                run;
  logic                wr_ok;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [ADDR_W-1:0]   rd_addr_a [NUM_RD];
  logic [NUM_RD-1:0]   bypass_hit;

  // Init walk FSM: one clearing write per cycle, DEPTH cycles after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + (ADDR_W + 1)'(1);
          if (cnt_q == CntLast) begin
            state_q     <= ST_RUN;
            init_busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q     <= ST_INIT;
          init_busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign init_busy = init_busy_q | rst;
  assign run       = (state_q == ST_RUN) && !rst;
  assign wr_ok     = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // Single storage write port shared by the init walk and writeback.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[ADDR_W-1:0];
        mem_wdata = '0;
      end else if (wr_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read ports with same-cycle write bypass.
  always_comb begin
    rd_data    = '0;
    bypass_hit = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_addr_a[k]  = ADDR_W'(port_slice(SLICE_VEC_W'(rd_addr), k, ADDR_W));
      bypass_hit[k] = run && wr_ok && (wr_addr == rd_addr_a[k]);
      if (!run) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (rd_addr_a[k] == '0)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end else if (bypass_hit[k]) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = mem_q[rd_addr_a[k]];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk_i       (clk),
    .rst_i       (rst),
    .run_i       (run),
    .claim_en_i  (claim_en),
    .claim_addr_i(claim_addr),
    .clr_en_i    (wr_en),
    .clr_addr_i  (wr_addr),
    .rd_addr_i   (rd_addr),
    .bypass_hit_i(bypass_hit),
    .rd_busy_o   (rd_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one instance with ZERO_REG = 1 and one with
// ZERO_REG = 0 driven by the same stimulus.
module tb_regfile_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR*AW-1:0] rd_addr;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           claim_en;
  logic [AW-1:0]  claim_addr;

  logic           init_busy, init_busy_nz;
  logic [NR*DW-1:0] rd_data, rd_data_nz;
  logic [NR-1:0]  rd_busy, rd_busy_nz;

  int total = 0;
  int bad   = 0;
  int n;
  logic [63:0] acc;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .claim_en  (claim_en),
    .claim_addr(claim_addr)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_nz (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy_nz),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data_nz),
    .rd_busy   (rd_busy_nz),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .claim_en  (claim_en),
    .claim_addr(claim_addr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0; rd_addr = '0;

    // Reset held for three edges.
    tick(); tick(); tick();
    check("rst_init_busy", {63'd0, init_busy}, 64'd1);
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_rd_busy", {62'd0, rd_busy}, 64'd0);

    // Release reset; writes and claims issued during the walk must be ignored.
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hFFFF_FFFF;
    claim_en = 1'b1; claim_addr = 5'd7;
    set_rd(5'd7, 5'd7);
    check("init_rd_data", rd_data, 64'd0);
    n = 0;
    while (init_busy && n < 100) begin
      n++;
      tick();
    end
    check("init_cycles", 64'(n), 64'd32);
    check("init_cycles_nz", {63'd0, init_busy_nz}, 64'd0);
    wr_en = 1'b0; claim_en = 1'b0;

    acc = '0;
    for (int r = 0; r < 32; r++) begin
      set_rd(5'(r), 5'(31 - r));
      acc = acc | rd_data | rd_data_nz | {60'd0, rd_busy, rd_busy_nz};
    end
    check("post_init_all_zero", acc, 64'd0);

    // Same-cycle bypass, then storage after the edge.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    set_rd(5'd7, 5'd1);
    check("bypass_r7", {32'd0, rd_data[31:0]}, 64'h0000_0000_DEAD_BEEF);
    tick();
    wr_en = 1'b0;
    #1;
    check("stored_r7", {32'd0, rd_data[31:0]}, 64'h0000_0000_DEAD_BEEF);

    // Register 0: hardwired with ZERO_REG = 1, ordinary with ZERO_REG = 0.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234;
    claim_en = 1'b1; claim_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    check("zero_bypass", rd_data, 64'd0);
    check("nz_bypass", rd_data_nz, 64'h0000_1234_0000_1234);
    tick();
    wr_en = 1'b0; claim_en = 1'b0;
    #1;
    check("zero_data", rd_data, 64'd0);
    check("zero_busy", {62'd0, rd_busy}, 64'd0);
    check("nz_data", rd_data_nz, 64'h0000_1234_0000_1234);
    check("nz_busy_claim_wins", {62'd0, rd_busy_nz}, 64'd3);

    // Claim, then retire through a write on register 5.
    claim_en = 1'b1; claim_addr = 5'd5;
    set_rd(5'd6, 5'd5);
    check("claim_same_cycle", {62'd0, rd_busy}, 64'd0);
    tick();
    claim_en = 1'b0;
    #1;
    check("claim_next_cycle", {62'd0, rd_busy}, 64'd2);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_A5A5;
    #1;
    check("write_cycle_busy", {62'd0, rd_busy}, 64'd0);
    check("write_cycle_data", {32'd0, rd_data[63:32]}, 64'h0000_A5A5);
    tick();
    wr_en = 1'b0;
    #1;
    check("after_write_busy", {62'd0, rd_busy}, 64'd0);
    check("after_write_data", {32'd0, rd_data[63:32]}, 64'h0000_A5A5);

    // Simultaneous claim and write on register 9.
    claim_en = 1'b1; claim_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_9999;
    set_rd(5'd9, 5'd5);
    check("sim_bypass_busy", {62'd0, rd_busy}, 64'd0);
    tick();
    claim_en = 1'b0; wr_en = 1'b0;
    #1;
    check("sim_busy_kept", {62'd0, rd_busy}, 64'd1);
    check("sim_data", {32'd0, rd_data[31:0]}, 64'h0000_9999);

    // Mid-operation reset.
    claim_en = 1'b1; claim_addr = 5'd3;
    tick();
    claim_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0055;
    tick();
    claim_en = 1'b0; wr_en = 1'b0;
    set_rd(5'd3, 5'd4);
    check("pre_rst_busy", {62'd0, rd_busy}, 64'd2);
    check("pre_rst_data", {32'd0, rd_data[31:0]}, 64'h0000_0055);
    rst = 1'b1;
    #1;
    check("mid_rst_init_busy", {63'd0, init_busy}, 64'd1);
    check("mid_rst_outputs", {rd_data[61:0], rd_busy}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    n = 0;
    while (init_busy && n < 100) begin
      n++;
      tick();
    end
    check("reinit_cycles", 64'(n), 64'd32);
    check("reinit_busy", {62'd0, rd_busy}, 64'd0);
    check("reinit_data", rd_data, 64'd0);
    set_rd(5'd9, 5'd5);
    check("reinit_busy_r9", {62'd0, rd_busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file for the pipelined MIPS core. It provides NUM_RD asynchronous read ports, one write port, write-to-read bypass and a per-register pending-write scoreboard for hazard detection. After reset it clears the array with a sequential init walk, so the storage can map to RAM. It sits between decode (reads and claims) and writeback (writes).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 is hardwired to 0 and is never busy

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- init_busy  out  1  high while reset or the init walk is in progress
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses slice [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data per port, combinational
- rd_busy  out  NUM_RD  per-port flag: the addressed register has an outstanding claim
- wr_en  in  1  writeback write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- claim_en  in  1  decode marks a destination register as pending
- claim_addr  in  ADDR_W  register being claimed

## Operation
FSM states: INIT and RUN.
- While rst is high: state = INIT, cnt = 0, all busy bits are cleared.
- INIT with rst low: each cycle writes mem[cnt] = 0 and increments cnt. On the cycle where cnt = DEPTH-1, the FSM performs that last write and moves to RUN.
- RUN is left only through rst.

In INIT:
- wr_en and claim_en are ignored.
- rd_data = 0 and rd_busy = 0 on all ports.
- init_busy = 1.

Writes in RUN:
- If wr_en is high, mem[wr_addr] takes wr_data at posedge.
- If ZERO_REG = 1, writes to address 0 are discarded.

Reads in RUN, per port k:
- If wr_en is high, wr_addr equals rd_addr[k], and the write is not to a discarded address 0, then rd_data[k] = wr_data. This is a same-cycle bypass.
- Otherwise rd_data[k] = mem[rd_addr[k]].
- If ZERO_REG = 1 and rd_addr[k] = 0, rd_data[k] = 0.

Scoreboard in RUN, one busy bit per register:
- claim_en sets busy[claim_addr] at posedge.
- wr_en clears busy[wr_addr] at posedge.
- If claim and write target the same register in the same cycle, the claim wins and busy stays 1. This models a new producer issuing while the old one writes back.
- If ZERO_REG = 1, claims to register 0 are ignored.
- rd_busy[k] = busy[rd_addr[k]] & ~bypass_hit[k]. A register being written this cycle reads as not busy, because the bypass supplies its value.

Arithmetic and widths:
- cnt is ADDR_W+1 bits so the DEPTH-1 terminal compare is unambiguous.
- Address compares are full ADDR_W-bit compares.

## Timing
- Reset values: init_busy = 1, rd_data = 0, rd_busy = 0, state = INIT, all busy bits = 0.
- After rst falls, init_busy stays high for exactly DEPTH cycles. The first RUN cycle follows the DEPTH-th posedge after rst deasserts.
- Write latency: a value written at edge N is visible from mem on the reads after edge N. It is visible through the bypass in the cycle before edge N.
- Claim latency: rd_busy reflects a claim in the cycle after the claiming edge.
- Read path is purely combinational; there is no read latency.
- rst asserted mid-walk or mid-RUN restarts INIT from cnt = 0 and drops all pending claims. The array contents are undefined until the walk completes.

## Structure
- Package regfile_pkg holds:
  - the state enum {ST_INIT, ST_RUN};
  - default parameter constants (DATA_W_DEF, ADDR_W_DEF, NUM_RD_DEF);
  - a helper function for port slice extraction.
- Sub-module regfile_scoreboard holds the DEPTH busy bits, claim/clear priority and the ZERO_REG masking. It takes the read addresses and bypass hits and produces rd_busy.
- Storage, the init FSM and the bypass muxes stay in regfile_sb.

## Test plan
- Init walk, DEPTH = 32: hold rst 3 cycles then release. Required: init_busy high for 32 cycles, then low. Writes issued during INIT are ignored. Reading every register afterwards returns 0.
- Write/read with bypass: in RUN, wr_en = 1, wr_addr = 7, wr_data = 0xDEADBEEF, rd_addr[0] = 7 in the same cycle. Required: rd_data[0] = 0xDEADBEEF that cycle, and it remains after the edge with wr_en = 0.
- Zero register: write 0x1234 to address 0 and claim address 0. Required: rd_data = 0 and rd_busy = 0 on reads of address 0. With ZERO_REG = 0, the same stimulus returns 0x1234.
- Scoreboard: claim reg 5 and read port 1 at address 5 → rd_busy[1] = 1 next cycle. Write reg 5 → rd_busy[1] = 0 in the write cycle (bypass), and busy stays clear afterwards.
- Simultaneous claim and write on reg 9 → busy stays 1 after the edge, and mem[9] holds the new data.
- Reset mid-operation: claim regs 3 and 4, write reg 3 = 0x55, assert rst for 1 cycle. Required: DEPTH-cycle init repeats, all rd_busy = 0, and reg 3 reads 0 after init.
